// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared types and helpers for the LED column-scan controller.
//   scan_state_t : scan FSM states (IDLE, BLANK, SHOW)
//   max2()       : constant-foldable max, used to size the cycle timer
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_scan_controller_cycle_timer.sv
// cycle_timer: loadable down-counter with a done flag.
//   clk, rst     : clock, synchronous active-high reset (clears the count)
//   load_i       : load load_val_i this edge (takes priority over counting)
//   load_val_i   : phase length minus one
//   done_o       : count has reached zero (last cycle of the loaded phase)
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);  // saturate at zero
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller: column-scan sequencer for an N x N LED array with a
// single-entry pending frame buffer swapped in only at frame boundaries.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : run scanning; low returns to IDLE on the next edge
//   frame_in     : new frame, bit N*j+i is LED (i,j)
//   frame_valid  : frame_in offered (accepted when frame_ready is high)
//   frame_ready  : pending buffer can take a frame
//   cells        : display buffer driven to the LED driver
//   x            : current scan column
//   drv_ena      : driver enable, high only while showing a column
//   frame_start  : one-cycle pulse on the first BLANK cycle of column 0
module led_scan_controller import led_scan_pkg::*; #(
  parameter int N        = 8,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N*N-1:0]     frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [N*N-1:0]     cells,
  output logic [$clog2(N):0] x,
  output logic               drv_ena,
  output logic               frame_start
);

  localparam int XW = $clog2(N) + 1;
  localparam int TW = $clog2(max2(PRESCALE, BLANK)) + 1;
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK - 1);
  localparam logic [TW-1:0] SHOW_LD  = TW'(PRESCALE - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(N - 1);

  scan_state_t         state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic                drv_q, drv_d;
  logic                fs_q, fs_d;
  logic [N*N-1:0]      cells_q, cells_d;
  logic [N*N-1:0]      pend_q, pend_d;
  logic                pf_q, pf_d;
  logic                rdy_q, rdy_d;
  logic                tmr_load, tmr_done;
  logic [TW-1:0]       tmr_ld_val;

  cycle_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_ld_val),
    .done_o    (tmr_done)
  );

  // State register (plus all other registered outputs)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= led_scan_pkg::IDLE;
      x_q     <= '0;
      drv_q   <= 1'b0;
      fs_q    <= 1'b0;
      cells_q <= '0;
      pend_q  <= '0;
      pf_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      drv_q   <= drv_d;
      fs_q    <= fs_d;
      cells_q <= cells_d;
      pend_q  <= pend_d;
      pf_q    <= pf_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = led_scan_pkg::IDLE;
    end else begin
      unique case (state_q)
        led_scan_pkg::IDLE:  state_d = led_scan_pkg::BLANK;
        led_scan_pkg::BLANK: if (tmr_done) state_d = led_scan_pkg::SHOW;
        led_scan_pkg::SHOW:  if (tmr_done) state_d = led_scan_pkg::BLANK;
        default:             state_d = led_scan_pkg::IDLE;
      endcase
    end
  end

  // Output / datapath control; values are those seen in the state being entered
  always_comb begin
    x_d        = x_q;
    fs_d       = 1'b0;
    tmr_load   = 1'b0;
    tmr_ld_val = BLANK_LD;
    drv_d      = (state_d == led_scan_pkg::SHOW);
    if (state_d == led_scan_pkg::IDLE) begin
      x_d = '0;
    end else if (state_q == led_scan_pkg::IDLE) begin
      // scanning restarts at column 0, which is a fresh frame
      x_d      = '0;
      fs_d     = 1'b1;
      tmr_load = 1'b1;
    end else if (state_q == led_scan_pkg::SHOW && state_d == led_scan_pkg::BLANK) begin
      x_d      = (x_q == X_LAST) ? '0 : x_q + XW'(1);
      fs_d     = (x_q == X_LAST);
      tmr_load = 1'b1;
    end else if (state_q == led_scan_pkg::BLANK && state_d == led_scan_pkg::SHOW) begin
      tmr_load   = 1'b1;
      tmr_ld_val = SHOW_LD;
    end
  end

  // Frame buffer: swap on the edge entering frame_start, accept on handshake.
  // frame_ready looks at both old and new pending_full so it stays low through
  // the swap cycle and only reopens the cycle after.
  always_comb begin
    cells_d = cells_q;
    pend_d  = pend_q;
    pf_d    = pf_q;
    if (fs_d && pf_q) begin
      cells_d = pend_q;
      pf_d    = 1'b0;
    end
    if (frame_valid && rdy_q) begin
      pend_d = frame_in;
      pf_d   = 1'b1;
    end
    rdy_d = !pf_d && !pf_q;
  end

  assign frame_ready = rdy_q;
  assign cells       = cells_q;
  assign x           = x_q;
  assign drv_ena     = drv_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_controller.sv
module tb_led_scan_controller;
  localparam int N  = 8;
  localparam int P  = 4;
  localparam int B  = 2;
  localparam int CP = B + P;
  localparam int FP = N * CP;
  localparam int W  = N * N;
  localparam int XW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          frame_valid = 1'b0;
  logic [W-1:0]  frame_in = '0;
  logic          frame_ready, drv_ena, frame_start;
  logic [W-1:0]  cells;
  logic [XW-1:0] x;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  led_scan_controller #(.N(N), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .cells(cells),
    .x(x), .drv_ena(drv_ena), .frame_start(frame_start)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_t is the cycle count since scanning (re)started,
  // modulo the frame period; everything visible derives from it.
  bit           m_run = 1'b0;
  int           m_t = 0;
  logic [W-1:0] m_cells = '0, m_pend = '0;
  bit           m_pf = 1'b0, m_rdy = 1'b0;

  always @(posedge clk) begin
    bit run_n, fs_n, pf_n;
    int t_n;
    logic [W-1:0] cells_n, pend_n;
    if (rst) begin
      m_run <= 1'b0; m_t <= 0; m_cells <= '0; m_pend <= '0; m_pf <= 1'b0; m_rdy <= 1'b0;
    end else begin
      run_n = enable;
      t_n   = (enable && m_run) ? (m_t + 1) % FP : 0;
      fs_n  = run_n && (t_n == 0);
      cells_n = m_cells; pend_n = m_pend; pf_n = m_pf;
      if (fs_n && m_pf) begin cells_n = m_pend; pf_n = 1'b0; end
      if (frame_valid && m_rdy) begin pend_n = frame_in; pf_n = 1'b1; end
      m_run <= run_n; m_t <= t_n; m_cells <= cells_n; m_pend <= pend_n; m_pf <= pf_n;
      // ready is low while a frame is pending and for the cycle it drains
      m_rdy <= !pf_n && !m_pf;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x",           64'(x),           m_run ? 64'(m_t / CP) : 64'd0);
      chk("drv_ena",     64'(drv_ena),     64'(m_run && (m_t % CP) >= B));
      chk("frame_start", 64'(frame_start), 64'(m_run && m_t == 0));
      chk("frame_ready", 64'(frame_ready), 64'(m_rdy));
      chk("cells",       cells,            m_cells);
    end
  end

  task automatic wait_fs(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 200);
    if (!frame_start) begin
      checks++; errs++;
      $display("FAIL %s: frame_start got 0 expected 1 within 200 cycles", nm);
    end
  endtask

  task automatic wait_col_show(input string nm, input int col);
    int n = 0;
    while (!(int'(x) == col && drv_ena) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errs++;
      $display("FAIL %s: column %0d SHOW got none expected within 200 cycles", nm, col);
    end
  endtask

  initial begin
    logic [11:0]  pat;
    logic [W-1:0] saved;
    pat = 12'b111100111100;

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 64'(frame_ready), 64'd0);
    chk("rst_cells", cells, 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(frame_ready), 64'd1);

    // scan timing
    enable = 1'b1;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      if (i < 12) chk("drv_pattern", 64'(drv_ena), 64'(pat[i]));
      if (i == 0 || i == 48) chk("fs_pulse", 64'(frame_start), 64'd1);
      if (i == 47) chk("fs_low", 64'(frame_start), 64'd0);
      if (i == 6) chk("x_step", 64'(x), 64'd1);
      if (i == 47) chk("x_last", 64'(x), 64'd7);
    end

    // single frame, mid-frame offer
    repeat (10) @(negedge clk);
    frame_in = 64'h1; frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    chk("acc1_ready", 64'(frame_ready), 64'd0);
    chk("acc1_cells", cells, 64'd0);
    wait_fs("wait_swap1");
    chk("swap1_cells", cells, 64'h1);
    chk("swap1_ready", 64'(frame_ready), 64'd0);
    @(negedge clk);
    chk("ready_back", 64'(frame_ready), 64'd1);

    // A then B back to back; B held valid through the swap cycle
    frame_in = 64'hA; frame_valid = 1'b1;
    @(negedge clk);
    frame_in = 64'hB;
    @(negedge clk);
    chk("stall_ready", 64'(frame_ready), 64'd0);
    wait_fs("wait_swapA");
    chk("swapA_cells", cells, 64'hA);
    chk("swap_cycle_ready", 64'(frame_ready), 64'd0);
    @(negedge clk);
    chk("B_ready_after_swap", 64'(frame_ready), 64'd1);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("B_accepted", 64'(frame_ready), 64'd0);
    wait_fs("wait_swapB");
    chk("swapB_cells", cells, 64'hB);

    // enable drop at column 5 during SHOW
    wait_col_show("wait_x5", 5);
    saved = cells;
    enable = 1'b0;
    @(negedge clk);
    chk("dis_x", 64'(x), 64'd0);
    chk("dis_drv", 64'(drv_ena), 64'd0);
    chk("dis_cells", cells, saved);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    frame_in = 64'hE; frame_valid = 1'b1;
    @(negedge clk);
    chk("reen_fs", 64'(frame_start), 64'd1);
    frame_valid = 1'b0;

    // reset at column 3 with a frame pending
    wait_col_show("wait_x3", 3);
    chk("pend_full_ready", 64'(frame_ready), 64'd0);
    rst = 1'b1; frame_in = 64'hF; frame_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_cells", cells, 64'd0);
      chk("mid_rst_ready", 64'(frame_ready), 64'd0);
    end
    rst = 1'b0; frame_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(frame_ready), 64'd1);
    wait_fs("wait_post_rst");
    chk("lost_pending", cells, 64'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if (!frame_valid || frame_ready || $urandom_range(0, 3) == 0) begin
        frame_valid = ($urandom_range(0, 2) == 0);
        frame_in = {$urandom, $urandom};
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
